// File: rtl/fetch_buffer.sv
// Instruction fetch stage: one outstanding imem request, returned words queued with their PCs.
// Define FETCH_BYPASS_EN to forward a response straight to the core when the queue is empty.
module fetch_buffer #(
  parameter int                 a_width  = 8,
  parameter int                 d_width  = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [a_width-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [a_width-1:0] imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [d_width-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [a_width-1:0] redirect_pc,
  output logic               ins_valid,
  input  logic               ins_ready,
  output logic [d_width-1:0] ins,
  output logic [a_width-1:0] ins_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;

  state_t             state;
  logic [a_width-1:0] fetch_pc;
  logic [a_width-1:0] pend_pc;
  logic [d_width-1:0] mem_data [DEPTH];
  logic [a_width-1:0] mem_pc   [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  logic issue_ok;
  logic grant;
  logic nonempty;
  logic resp_ok;
  logic bypass;
  logic push;
  logic pop;

  // Only issue when the queue can hold the answer, so it never overflows.
  assign issue_ok  = (state == REQ) && (count < FULL) && !redirect;
  assign grant     = issue_ok && imem_gnt;
  assign imem_req  = issue_ok && rst_n;
  assign imem_addr = fetch_pc;

  assign nonempty = (count != '0);
  assign resp_ok  = (state == WAIT) && imem_rvalid && !redirect;

`ifdef FETCH_BYPASS_EN
  assign bypass = resp_ok && !nonempty;
`else
  assign bypass = 1'b0;
`endif

  assign ins_valid = (nonempty || bypass) && !redirect;
  assign push      = resp_ok && !(bypass && ins_ready);
  assign pop       = nonempty && ins_ready && !redirect;

  always_comb begin
    ins    = '0;
    ins_pc = '0;
    if (bypass) begin
      ins    = imem_rdata;
      ins_pc = pend_pc;
    end else if (nonempty) begin
      ins    = mem_data[rd_ptr];
      ins_pc = mem_pc[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= REQ;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      // An in-flight request must still be drained; its word is thrown away.
      if (state != REQ) state <= imem_rvalid ? REQ : DROP;
    end else begin
      case (state)
        REQ:      if (grant) begin
                    fetch_pc <= fetch_pc + a_width'(4);
                    state    <= WAIT;
                  end
        WAIT,
        DROP:     if (imem_rvalid) state <= REQ;
        default:  state <= REQ;
      endcase
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Datapath storage carries no reset; validity comes from count/state.
  always_ff @(posedge clk) begin
    if (grant) pend_pc <= fetch_pc;
    if (push) begin
      mem_data[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr]   <= pend_pc;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: vector table, directed corner sequences, random traffic vs. a stream model.
module tb_fetch_buffer;

  localparam int         AW    = 8;
  localparam int         DW    = 32;
  localparam int         DEPTH = 4;
  localparam logic [7:0] RPC   = 8'h00;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [DW-1:0] imem_rdata = '0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          ins_valid;
  logic          ins_ready = 1'b0;
  logic [DW-1:0] ins;
  logic [AW-1:0] ins_pc;

  always #5 clk = ~clk;

  fetch_buffer #(.a_width(AW), .d_width(DW), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins), .ins_pc(ins_pc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model and expected instruction stream
  bit         man = 1'b0;
  bit         mem_out = 1'b0;
  logic [7:0] mem_addr = '0;
  int         mem_cnt = 0;
  int         lat_min = 1, lat_max = 1, gnt_pct = 100;
  logic [7:0] exp_req = RPC, exp_ins = RPC;
  int         grants = 0, delivers = 0;
  logic [7:0] gq[$];

  function automatic logic [31:0] word(input logic [7:0] a);
    return {a, 8'hA5, ~a, a ^ 8'h3C};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic settle();
    if (!man) begin
      imem_gnt    = ($urandom_range(99) < gnt_pct);
      imem_rvalid = mem_out && (mem_cnt == 0);
      imem_rdata  = imem_rvalid ? word(mem_addr) : 32'h0BAD_0BAD;
    end
    #1;
  endtask

  // Scoreboard plus memory bookkeeping, then move to the next negedge.
  task automatic adv();
    if (!rst_n) begin
      exp_req = RPC;
      exp_ins = RPC;
      mem_out = 1'b0;
    end else begin
      chk("single_outstanding", imem_req & mem_out, 0);
      if (redirect) begin
        chk("valid_in_redirect", ins_valid, 0);
        exp_req = redirect_pc;
        exp_ins = redirect_pc;
      end else begin
        if (imem_req && imem_gnt) begin
          chk("req_addr", imem_addr, exp_req);
          exp_req = exp_req + 8'd4;
        end
        if (ins_valid && ins_ready) begin
          chk("stream_pc", ins_pc, exp_ins);
          chk("stream_ins", ins, word(exp_ins));
          exp_ins = exp_ins + 8'd4;
          delivers++;
        end
      end
      if (imem_req && imem_gnt) begin
        grants++;
        gq.push_back(imem_addr);
      end
      if (imem_rvalid) mem_out = 1'b0;
      else if (mem_out) mem_cnt--;
      if (imem_req && imem_gnt) begin
        mem_out  = 1'b1;
        mem_addr = imem_addr;
        mem_cnt  = $urandom_range(lat_max, lat_min) - 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect = 1'b0; ins_ready = 1'b0; man = 1'b0;
    lat_min = 1; lat_max = 1; gnt_pct = 100;
    settle();
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, RPC);
    chk("rst_ins_valid", ins_valid, 0);
    chk("rst_ins", ins, 0);
    chk("rst_ins_pc", ins_pc, 0);
    adv();
    adv();
    rst_n = 1'b1;
    grants = 0; delivers = 0; gq.delete();
  endtask

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        req;
    logic [7:0]  addr;
    logic        valid;
    logic [7:0]  pc;
  } vec_t;

  vec_t tbl[10];
  bit   found;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Always-grant, 1-cycle memory, core always ready.
    for (int c = 0; c < 10; c++) begin
      automatic int k = c / 2;
      tbl[c].gnt = 1'b1;
      if (c % 2 == 0) begin
        tbl[c].rvalid = 1'b0;
        tbl[c].rdata  = 32'h0;
        tbl[c].req    = 1'b1;
        tbl[c].addr   = 8'(4 * k);
`ifdef FETCH_BYPASS_EN
        tbl[c].valid  = 1'b0;
        tbl[c].pc     = 8'h00;
`else
        tbl[c].valid  = (k >= 1);
        tbl[c].pc     = (k >= 1) ? 8'(4 * (k - 1)) : 8'h00;
`endif
      end else begin
        tbl[c].rvalid = 1'b1;
        tbl[c].rdata  = word(8'(4 * k));
        tbl[c].req    = 1'b0;
        tbl[c].addr   = 8'(4 * (k + 1));
`ifdef FETCH_BYPASS_EN
        tbl[c].valid  = 1'b1;
        tbl[c].pc     = 8'(4 * k);
`else
        tbl[c].valid  = 1'b0;
        tbl[c].pc     = 8'h00;
`endif
      end
    end

    do_reset();
    man = 1'b1;
    ins_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      imem_gnt = tbl[c].gnt; imem_rvalid = tbl[c].rvalid; imem_rdata = tbl[c].rdata;
      settle();
      chk("tbl_req", imem_req, tbl[c].req);
      chk("tbl_addr", imem_addr, tbl[c].addr);
      chk("tbl_valid", ins_valid, tbl[c].valid);
      if (tbl[c].valid) begin
        chk("tbl_pc", ins_pc, tbl[c].pc);
        chk("tbl_ins", ins, word(tbl[c].pc));
      end
      adv();
    end
    man = 1'b0;

    // Core stalled: exactly DEPTH requests, then one pop restarts fetch.
    do_reset();
    repeat (12) begin settle(); adv(); end
    settle();
    chk("full_grants", grants, DEPTH);
    chk("full_req", imem_req, 0);
    chk("full_valid", ins_valid, 1);
    chk("full_pc", ins_pc, 8'h00);
    ins_ready = 1'b1;
    adv();
    ins_ready = 1'b0;
    settle();
    chk("pop_req", imem_req, 1);
    chk("pop_addr", imem_addr, 8'h10);
    adv();

    // Redirect while waiting; the old response shows up two cycles later.
    do_reset();
    ins_ready = 1'b1;
    lat_min = 3; lat_max = 3;
    settle(); chk("wr_req0", imem_req, 1); adv();
    lat_min = 1; lat_max = 1;
    redirect = 1'b1; redirect_pc = 8'h40;
    settle(); chk("wr_req_redir", imem_req, 0); chk("wr_valid_redir", ins_valid, 0); adv();
    redirect = 1'b0;
    settle(); chk("wr_drop_req", imem_req, 0); adv();
    settle(); chk("wr_stale_rvalid", imem_rvalid, 1); chk("wr_stale_valid", ins_valid, 0);
    chk("wr_stale_req", imem_req, 0); adv();
    settle(); chk("wr_new_req", imem_req, 1); chk("wr_new_addr", imem_addr, 8'h40); adv();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      settle();
      if (ins_valid) begin
        found = 1'b1;
        chk("wr_first_pc", ins_pc, 8'h40);
      end
      adv();
    end
    chk("wr_found", found, 1);

    // Redirect coincident with the response that fills the queue.
    do_reset();
    for (int i = 0; i < 20 && grants < DEPTH; i++) begin settle(); adv(); end
    chk("rf_grants", grants, DEPTH);
    redirect = 1'b1; redirect_pc = 8'h80;
    settle();
    chk("rf_rvalid", imem_rvalid, 1);
    chk("rf_valid", ins_valid, 0);
    chk("rf_req", imem_req, 0);
    adv();
    redirect = 1'b0;
    settle();
    chk("rf_valid_next", ins_valid, 0);
    chk("rf_req_next", imem_req, 1);
    chk("rf_addr_next", imem_addr, 8'h80);
    adv();

    // Address wrap at the top of the 8-bit space.
    do_reset();
    ins_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 8'hF8;
    settle(); adv();
    redirect = 1'b0;
    repeat (8) begin settle(); adv(); end
    chk("wrap_count", gq.size() >= 3, 1);
    if (gq.size() >= 3) begin
      chk("wrap_a0", gq[0], 8'hF8);
      chk("wrap_a1", gq[1], 8'hFC);
      chk("wrap_a2", gq[2], 8'h00);
    end

    // Reset during WAIT, then a stray response after release.
    do_reset();
    ins_ready = 1'b1;
    lat_min = 3; lat_max = 3;
    settle(); adv();
    settle(); adv();
    rst_n = 1'b0;
    settle();
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_addr", imem_addr, RPC);
    chk("mid_rst_valid", ins_valid, 0);
    adv();
    rst_n = 1'b1;
    man = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = word(8'h00);
    settle();
    chk("stray_valid", ins_valid, 0);
    chk("stray_req", imem_req, 1);
    chk("stray_addr", imem_addr, RPC);
    adv();
    imem_rvalid = 1'b0;
    settle();
    chk("stray_valid_after", ins_valid, 0);
    adv();
    man = 1'b0;

    // Random traffic against the sequential-stream model.
    do_reset();
    gnt_pct = 60; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      ins_ready   = ($urandom_range(99) < 70);
      redirect    = ($urandom_range(99) < 4);
      redirect_pc = 8'($urandom);
      settle();
      adv();
    end
    redirect = 1'b0;
    chk("rand_progress", delivers > 200, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction fetch stage sitting directly upstream of the RV32I decode/execute datapath. It generates sequential byte addresses (PC += 4), issues one outstanding request at a time to instruction memory, and buffers returned words with their PCs in a small FIFO. It presents them to the core over a valid/ready handshake. A redirect (branch/jump from the core) flushes the buffer, discards any in-flight response and restarts fetch at the new PC.

## Interface
- a_width, 8, instruction address width (byte address)
- d_width, 32, instruction width
- DEPTH, 4, FIFO entries (power of two, ≥2)
- RESET_PC, 0, fetch address after reset
- Reset: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  a_width  fetch address (= fetch_pc)
- imem_gnt  in  1  request accepted this cycle when imem_req=1
- imem_rvalid  in  1  response valid, ≥1 cycle after grant, at most one per grant
- imem_rdata  in  d_width  response instruction word
- redirect  in  1  flush and restart fetch
- redirect_pc  in  a_width  new fetch address, sampled when redirect=1
- ins_valid  out  1  ins/ins_pc valid
- ins_ready  in  1  core consumes head this cycle when ins_valid=1
- ins  out  d_width  instruction at head
- ins_pc  out  a_width  PC of ins

## Operation
- State: fetch_pc, pend_pc, FIFO (data+pc, rd/wr pointers, count 0..DEPTH), FSM.
- FSM states:
  - REQ: no outstanding request.
  - WAIT: one outstanding request, response kept.
  - DROP: one outstanding request, response to be discarded.
- imem_req = (state==REQ) && (count < DEPTH) && !redirect && rst_n. A request is issued only when the FIFO has room for its response, so the FIFO cannot overflow.
- REQ, imem_req && imem_gnt: pend_pc ← fetch_pc, fetch_pc ← fetch_pc + 4 (mod 2^a_width), go to WAIT.
- WAIT, imem_rvalid: push {imem_rdata, pend_pc}, go to REQ.
- WAIT, redirect: go to DROP. If imem_rvalid arrives the same cycle, discard it and go to REQ.
- DROP, imem_rvalid: discard the word, go to REQ. A redirect in DROP stays in DROP.
- Redirect, any state:
  - fetch_pc ← redirect_pc; FIFO count and pointers ← 0.
  - ins_valid forced 0 in the redirect cycle; any ins_ready in that cycle is ignored.
- ins_valid = (count != 0) && !redirect; ins/ins_pc = FIFO head.
- Pop when ins_valid && ins_ready. Push and pop in the same cycle leave count unchanged.
- Pointers wrap modulo DEPTH. fetch_pc wraps 0xFC → 0x00 for a_width=8.
- redirect_pc is used as given; no alignment check.

## Timing
- Reset values:
  - Outputs: imem_req=0, imem_addr=RESET_PC, ins_valid=0, ins=0, ins_pc=0.
  - Internal: state REQ, count 0.
- First imem_req=1 in the first cycle after rst_n deasserts.
- Reset asserted mid-transaction abandons the outstanding request. Any response arriving after reset is ignored because state is REQ.
- Latency, gnt in cycle N and rvalid in N+1: ins_valid=1 in N+2.
- Sustained throughput is one instruction per 2 cycles with a 1-cycle memory, because only one request is outstanding.
- Redirect in cycle R: next request with imem_addr=redirect_pc in R+1 (state REQ) or after the discarded response (state WAIT/DROP).
- FIFO full (count==DEPTH): imem_req=0 until a pop. The request is then reissued in the cycle after the pop.

## Configuration
- FETCH_BYPASS_EN
  - Defined: when count==0, state==WAIT, imem_rvalid=1 and !redirect, the word is bypassed combinationally: ins_valid=1, ins=imem_rdata, ins_pc=pend_pc. If ins_ready=1 the word is consumed and not pushed; otherwise it is pushed. Latency drops to N+1.
  - Undefined: no bypass; all words pass through the FIFO (latency N+2).

## Test plan
- Reset release, RESET_PC=0, memory always grants with 1-cycle response: imem_addr sequence 0x00,0x04,0x08…; ins_pc follows the same order with matching ins; ins_valid first at cycle 2 after the first grant (cycle 1 with FETCH_BYPASS_EN).
- ins_ready=0 held: exactly DEPTH=4 requests issued, then imem_req=0. Raise ins_ready for one cycle: one pop, and imem_req=1 in the next cycle.
- Redirect to 0x40 while in WAIT, response arriving 2 cycles later: that word is never presented. Next imem_addr=0x40 and next ins_pc=0x40.
- Redirect coincident with imem_rvalid and a full FIFO: ins_valid=0 that cycle, count=0 next cycle, next request at redirect_pc.
- fetch_pc=0xFC: next request address is 0x00 (wrap). Assert rst_n low mid-WAIT and deliver a stray rvalid: the word is discarded, imem_addr=RESET_PC, ins_valid stays 0.
